j_add23_arb: RTL

//  Shares the single 23-bit Jerry DSP adder (j_fa23 datapath) among NREQ requesters.
//  - Round-robin arbitration, optional per-owner lock for back-to-back accumulate bursts.
//  - Two-stage registered pipeline: operand capture, then sum; throughput one add per clock.
//  - Sits between the DSP address/phase-accumulator units and the shared adder instance.

---
 rtl/j_add23_pkg.sv | 42 ++++
 rtl/j_add23_arb_if.sv | 30 +++
 rtl/j_rr_arb.sv | 27 ++
 rtl/j_add23_arb.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/j_add23_pkg.sv
// Shared types and helpers for the Jerry 23-bit adder arbiter.
package j_add23_pkg;

    localparam int unsigned ADD_W   = 23;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic {
        ARB,
        LOCKED
    } state_e;

    // Captured operand pair plus the requester that issued it
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
    } op_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] idx;
    } pick_t;

    // First set req bit scanning upward from ptr+1, wrapping modulo nreq
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [ID_W-1:0]    ptr,
                                      input int unsigned        nreq);
        pick_t       p;
        int unsigned j;
        p = '0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            j = (32'(ptr) + i) % nreq;
            if (i <= nreq && !p.found && req[ID_W'(j)]) begin
                p.found = 1'b1;
                p.idx   = ID_W'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/j_add23_arb_if.sv
// Requester-side bus of the shared adder: requests, operands, grants and results.
// res_cy only exists when J_ADD23_SAT_EN is defined.
interface j_add23_arb_if #(
    parameter int unsigned NREQ = 4
);
    import j_add23_pkg::*;

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*ADD_W-1:0] a_in;
    logic [NREQ*ADD_W-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [ADD_W-1:0]      res;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
`ifdef J_ADD23_SAT_EN
    logic                  res_cy;

    modport master (output req, lock, a_in, b_in,
                    input  gnt, res, res_valid, res_id, res_cy);
    modport slave  (input  req, lock, a_in, b_in,
                    output gnt, res, res_valid, res_id, res_cy);
`else
    modport master (output req, lock, a_in, b_in,
                    input  gnt, res, res_valid, res_id);
    modport slave  (input  req, lock, a_in, b_in,
                    output gnt, res, res_valid, res_id);
`endif

endinterface

// File: rtl/j_rr_arb.sv
// Combinational round-robin picker: request vector and last-winner pointer
// to one-hot grant and winner index.
module j_rr_arb
    import j_add23_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt_c,
    output logic [ID_W-1:0] idx_c,
    output logic            any_c
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(req), ptr, NREQ);
        any_c = pick.found;
        idx_c = pick.idx;
        gnt_c = '0;
        if (pick.found) begin
            gnt_c = NREQ'(1) << pick.idx;
        end
    end

endmodule

// File: rtl/j_add23_arb.sv
// Round-robin arbiter with owner lock in front of the shared 23-bit Jerry adder,
// two-stage pipeline (operand capture, sum). Optional: J_ADD23_SAT_EN (saturate + res_cy).
module j_add23_arb
    import j_add23_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned LOCK_TMO = 15
) (
    input logic          sys_clk,
    input logic          reset,
    j_add23_arb_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(LOCK_TMO + 1);

    state_e           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  owner;
    logic [CNT_W-1:0] cnt;

    logic [NREQ-1:0]  rr_gnt_c;
    logic [ID_W-1:0]  rr_idx_c;
    logic             rr_any_c;
    logic [NREQ-1:0]  owner_hot;
    logic [NREQ-1:0]  gnt_c;
    logic             fire_c;
    logic             owner_req_c;
    logic             owner_lock_c;

    op_t              op_c;
    op_t              s1_op;
    logic             s1_valid;

    j_rr_arb #(.NREQ(NREQ)) u_rr (
        .req   (bus.req),
        .ptr   (ptr),
        .gnt_c (rr_gnt_c),
        .idx_c (rr_idx_c),
        .any_c (rr_any_c)
    );

    assign owner_hot    = NREQ'(1) << owner;
    assign owner_req_c  = |(bus.req & owner_hot);
    assign owner_lock_c = |(bus.lock & owner_hot);

    // While locked only the owner may be granted; nothing is granted under reset
    always_comb begin
        gnt_c = '0;
        if (!reset) begin
            if (state == ARB) begin
                gnt_c = rr_gnt_c;
            end else begin
                gnt_c = bus.req & owner_hot;
            end
        end
    end

    assign bus.gnt = gnt_c;
    assign fire_c  = |gnt_c;

    always_comb begin
        op_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                op_c.id = ID_W'(i);
                op_c.a  = bus.a_in[ADD_W*i +: ADD_W];
                op_c.b  = bus.b_in[ADD_W*i +: ADD_W];
            end
        end
    end

`ifdef J_ADD23_SAT_EN
    logic [ADD_W:0] sum_c;
    assign sum_c = {1'b0, s1_op.a} + {1'b0, s1_op.b};
`else
    logic [ADD_W-1:0] sum_c;
    assign sum_c = s1_op.a + s1_op.b;
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state         <= ARB;
            ptr           <= ID_W'(NREQ - 1);
            owner         <= '0;
            cnt           <= '0;
            s1_valid      <= 1'b0;
            s1_op         <= '0;
            bus.res       <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
`ifdef J_ADD23_SAT_EN
            bus.res_cy    <= 1'b0;
`endif
        end else begin
            case (state)
                ARB: begin
                    if (rr_any_c) begin
                        ptr <= rr_idx_c;
                        if (|(bus.lock & rr_gnt_c)) begin
                            state <= LOCKED;
                            owner <= rr_idx_c;
                            cnt   <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (owner_req_c) begin
                        if (owner_lock_c) begin
                            cnt <= '0;
                        end else begin
                            state <= ARB;
                        end
                    end else if (cnt == CNT_W'(LOCK_TMO - 1)) begin
                        // Idle owner held the lock too long: release without a grant
                        state <= ARB;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ARB;
            endcase

            s1_valid <= fire_c;
            if (fire_c) begin
                s1_op <= op_c;
            end

            bus.res_valid <= s1_valid;
            if (s1_valid) begin
                bus.res_id <= s1_op.id;
`ifdef J_ADD23_SAT_EN
                bus.res    <= sum_c[ADD_W] ? '1 : sum_c[ADD_W-1:0];
                bus.res_cy <= sum_c[ADD_W];
`else
                bus.res    <= sum_c;
`endif
            end
        end
    end

endmodule
